// File: rtl/int8_decomp_pkg.sv
// Shared types and defaults for the int8 outlier-decomposition tile scheduler.
package int8_decomp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_TILE_CNT_WIDTH = 8;
  localparam int unsigned DEFAULT_TIMEOUT        = 1024;
  localparam int unsigned DEFAULT_TO_WIDTH       = 11;

endpackage

// File: rtl/fork_join_tracker.sv
// Per-tile fork/join bookkeeping for the large (FP16) and small (int8) branches.
module fork_join_tracker (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic active,
  input  logic large_ready,
  input  logic small_ready,
  input  logic large_res_valid,
  input  logic small_res_valid,
  output logic large_valid,
  output logic small_valid,
  output logic large_res_ready,
  output logic small_res_ready,
  output logic join_c
);

  logic sent_l_q;
  logic sent_s_q;
  logic ret_l_q;
  logic ret_s_q;

  // Results are only accepted once the dispatch flop is set, so a result can
  // never be consumed in the same cycle as its own dispatch.
  assign large_valid     = active && !sent_l_q;
  assign small_valid     = active && !sent_s_q;
  assign large_res_ready = active && sent_l_q && !ret_l_q;
  assign small_res_ready = active && sent_s_q && !ret_s_q;

  assign join_c = active
               && (ret_l_q || (large_res_valid && large_res_ready))
               && (ret_s_q || (small_res_valid && small_res_ready));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sent_l_q <= 1'b0;
      sent_s_q <= 1'b0;
      ret_l_q  <= 1'b0;
      ret_s_q  <= 1'b0;
    end else begin
      if (large_valid && large_ready)         sent_l_q <= 1'b1;
      if (small_valid && small_ready)         sent_s_q <= 1'b1;
      if (large_res_valid && large_res_ready) ret_l_q  <= 1'b1;
      if (small_res_valid && small_res_ready) ret_s_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/int8_decomp_sched.sv
// Frame sequencer: fetch a tile, fork it to both matmul branches, join, emit to gather.
module int8_decomp_sched
  import int8_decomp_pkg::*;
#(
  parameter int unsigned TILE_CNT_WIDTH = DEFAULT_TILE_CNT_WIDTH,
  parameter int unsigned TIMEOUT        = DEFAULT_TIMEOUT,
  parameter int unsigned TO_WIDTH       = DEFAULT_TO_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_num_tiles,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      large_valid,
  input  logic                      large_ready,
  output logic                      small_valid,
  input  logic                      small_ready,
  input  logic                      large_res_valid,
  output logic                      large_res_ready,
  input  logic                      small_res_valid,
  output logic                      small_res_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [TILE_CNT_WIDTH-1:0] tile_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  state_t                    state_q, state_d;
  logic [TILE_CNT_WIDTH-1:0] count_q, count_d;
  logic [TILE_CNT_WIDTH-1:0] tile_idx_q, tile_idx_d;
  logic [TO_WIDTH-1:0]       wdog_q, wdog_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;

  logic run_c;
  logic fetch_hs_c;
  logic last_c;
  logic join_c;

  assign run_c      = (state_q == RUN);
  assign fetch_hs_c = (state_q == FETCH) && in_valid;
  assign last_c     = (tile_idx_q == (count_q - TILE_CNT_WIDTH'(1)));

  fork_join_tracker u_tracker (
    .clk             (clk),
    .rst             (rst),
    .clr             (fetch_hs_c),
    .active          (run_c),
    .large_ready     (large_ready),
    .small_ready     (small_ready),
    .large_res_valid (large_res_valid),
    .small_res_valid (small_res_valid),
    .large_valid     (large_valid),
    .small_valid     (small_valid),
    .large_res_ready (large_res_ready),
    .small_res_ready (small_res_ready),
    .join_c          (join_c)
  );

  // Next-state and register update logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tile_idx_d = tile_idx_q;
    wdog_d     = wdog_q;
    err_d      = err_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (cfg_num_tiles != '0) begin
            count_d    = cfg_num_tiles;
            tile_idx_d = '0;
            state_d    = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (in_valid) begin
          wdog_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        wdog_d = wdog_q + TO_WIDTH'(1);
        if (join_c) begin
          state_d = EMIT;
        end else if (wdog_q == TO_WIDTH'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_c) begin
            done_d     = 1'b1;
            tile_idx_d = '0;
            state_d    = IDLE;
          end else begin
            tile_idx_d = tile_idx_q + TILE_CNT_WIDTH'(1);
            state_d    = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      tile_idx_q <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tile_idx_q <= tile_idx_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = (state_q == FETCH);
  assign out_valid = (state_q == EMIT);
  assign out_last  = (state_q == EMIT) && last_c;
  assign busy      = (state_q != IDLE);
  assign tile_idx  = tile_idx_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_int8_decomp_sched.sv
// Self-checking bench for int8_decomp_sched: per-cycle tile-level model plus directed timing checks.
module tb_int8_decomp_sched;

  localparam int unsigned TCW = 8;
  localparam int unsigned TO  = 16;
  localparam int unsigned TOW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [TCW-1:0] cfg = '0;
  logic           in_valid = 1'b1;
  logic           large_ready = 1'b1;
  logic           small_ready = 1'b1;
  logic           large_res_valid = 1'b0;
  logic           small_res_valid = 1'b0;
  logic           out_ready = 1'b1;

  logic           in_ready, large_valid, small_valid;
  logic           large_res_ready, small_res_ready;
  logic           out_valid, out_last, busy, done, err;
  logic [TCW-1:0] tile_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Environment knobs (set by the stimulus process while the scheduler is idle)
  int lr_wait = 0, sr_wait = 0, l_lat = 0, s_lat = 0, out_wait = 0;
  bit s_hold = 1'b0;

  // Observed output stream
  int outq[$];
  bit lastq[$];
  int done_cnt = 0;

  // Model state of the tile currently in flight
  bit m_busy = 0, m_fetch = 0, m_run = 0, m_emit = 0;
  bit m_sl = 0, m_ss = 0, m_rl = 0, m_rs = 0, m_err = 0, m_done = 0;
  int m_age = 0, m_idx = 0, m_n = 0;

  int_decomp_dummy_guard u_guard_unused ();

  int8_decomp_sched #(
    .TILE_CNT_WIDTH (TCW),
    .TIMEOUT        (TO),
    .TO_WIDTH       (TOW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_num_tiles   (cfg),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .large_valid     (large_valid),
    .large_ready     (large_ready),
    .small_valid     (small_valid),
    .small_ready     (small_ready),
    .large_res_valid (large_res_valid),
    .large_res_ready (large_res_ready),
    .small_res_valid (small_res_valid),
    .small_res_ready (small_res_ready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .tile_idx        (tile_idx),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Branch / gather environment: reacts to handshakes of the previous cycle.
  initial forever begin
    bit hl, hs, hrl, hrs, ho, pl, ps, po, pdone, prst;
    int l_seen, s_seen, o_seen, l_cd, s_cd;
    bit l_pend, s_pend;
    @(posedge clk);
    cyc++;
    hl = large_valid && large_ready;  hs = small_valid && small_ready;
    hrl = large_res_valid && large_res_ready;  hrs = small_res_valid && small_res_ready;
    ho = out_valid && out_ready;
    pl = large_valid;  ps = small_valid;  po = out_valid;  pdone = done;  prst = rst;
    #1;
    if (prst || pdone) begin
      l_seen = 0; s_seen = 0; o_seen = 0; l_cd = 0; s_cd = 0; l_pend = 0; s_pend = 0;
    end else begin
      if (hrl) l_pend = 0;
      if (hl) begin l_pend = 1; l_cd = l_lat; l_seen = 0; end
      else begin if (pl) l_seen++; if (l_pend && l_cd > 0) l_cd--; end
      if (hrs) s_pend = 0;
      if (hs) begin s_pend = 1; s_cd = s_lat; s_seen = 0; end
      else begin if (ps) s_seen++; if (s_pend && s_cd > 0) s_cd--; end
      if (ho) o_seen = 0; else if (po) o_seen++;
    end
    large_ready     = (l_seen >= lr_wait);
    small_ready     = (s_seen >= sr_wait);
    large_res_valid = l_pend && (l_cd == 0);
    small_res_valid = s_pend && (s_cd == 0) && !s_hold;
    out_ready       = (o_seen >= out_wait);
  end

  // Compare DUT against the tile-level model every cycle, then advance the model.
  initial forever begin
    bit dl, ds, rl, rs, n_done;
    @(negedge clk);
    chk("in_ready",        32'(in_ready),        32'(m_fetch));
    chk("large_valid",     32'(large_valid),     32'(m_run && !m_sl));
    chk("small_valid",     32'(small_valid),     32'(m_run && !m_ss));
    chk("large_res_ready", 32'(large_res_ready), 32'(m_run && m_sl && !m_rl));
    chk("small_res_ready", 32'(small_res_ready), 32'(m_run && m_ss && !m_rs));
    chk("out_valid",       32'(out_valid),       32'(m_emit));
    chk("out_last",        32'(out_last),        32'(m_emit && (m_idx == m_n - 1)));
    chk("tile_idx",        32'(tile_idx),        32'(m_idx));
    chk("busy",            32'(busy),            32'(m_busy));
    chk("done",            32'(done),            32'(m_done));
    chk("err",             32'(err),             32'(m_err));

    if (out_valid && out_ready) begin
      outq.push_back(int'(tile_idx));
      lastq.push_back(out_last);
    end
    if (done) done_cnt++;

    n_done = 0;
    if (rst) begin
      m_busy = 0; m_fetch = 0; m_run = 0; m_emit = 0;
      m_sl = 0; m_ss = 0; m_rl = 0; m_rs = 0; m_err = 0;
      m_age = 0; m_idx = 0; m_n = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_err = 0;
        if (cfg != 0) begin
          m_n = int'(cfg); m_idx = 0; m_busy = 1; m_fetch = 1;
        end else begin
          n_done = 1;
        end
      end
    end else if (m_fetch) begin
      if (in_valid) begin
        m_fetch = 0; m_run = 1; m_sl = 0; m_ss = 0; m_rl = 0; m_rs = 0; m_age = 0;
      end
    end else if (m_run) begin
      dl = !m_sl && large_ready;
      ds = !m_ss && small_ready;
      rl = m_sl && !m_rl && large_res_valid;
      rs = m_ss && !m_rs && small_res_valid;
      if ((m_rl || rl) && (m_rs || rs)) begin
        m_run = 0; m_emit = 1;
      end else if (m_age == TO - 1) begin
        m_run = 0; m_busy = 0; m_err = 1; n_done = 1;
      end
      m_sl = m_sl || dl;  m_ss = m_ss || ds;
      m_rl = m_rl || rl;  m_rs = m_rs || rs;
      m_age++;
    end else if (m_emit) begin
      if (out_ready) begin
        m_emit = 0;
        if (m_idx == m_n - 1) begin
          n_done = 1; m_busy = 0; m_idx = 0;
        end else begin
          m_idx++; m_fetch = 1;
        end
      end
    end
    m_done = n_done;
  end

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    cfg   = TCW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk(nm, 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int base, dbase, stall;
    bit seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_in_ready", 32'(in_ready),  32'd0);
    chk("rst_tile_idx", 32'(tile_idx),  32'd0);
    chk("rst_err",      32'(err),       32'd0);

    // Single tile, everything ready, results one cycle after dispatch
    pulse_start(1);
    @(negedge clk); chk("t1_in_ready_c1", 32'(in_ready), 32'd1);
    @(negedge clk); chk("t1_dispatch_c2", 32'(large_valid && small_valid), 32'd1);
    @(negedge clk); chk("t1_res_ready_c3", 32'(large_res_ready && small_res_ready), 32'd1);
    @(negedge clk); chk("t1_out_c4", 32'(out_valid && out_last), 32'd1);
    @(negedge clk); chk("t1_done_c5", 32'(done), 32'd1);
    chk("t1_busy_c5", 32'(busy), 32'd0);

    // Three tiles: large_ready stalls 3 cycles, small result returns first
    lr_wait = 3; l_lat = 2; s_lat = 0;
    base = outq.size(); dbase = done_cnt;
    pulse_start(3);
    wait_done("t3_done_timeout", 100);
    chk("t3_out_count", 32'(outq.size() - base), 32'd3);
    if (outq.size() - base == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("t3_tile_idx", 32'(outq[base + k]), 32'(k));
        chk("t3_out_last", 32'(lastq[base + k]), 32'(k == 2));
      end
    end
    chk("t3_done_pulses", 32'(done_cnt - dbase), 32'd1);
    lr_wait = 0; l_lat = 0;

    // Empty frame
    pulse_start(0);
    @(negedge clk);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("empty_in_ready", 32'(in_ready), 32'd0);
    end

    // Gather backpressure: out_ready low for 5 EMIT cycles
    out_wait = 5;
    pulse_start(2);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    chk("bp_reach_emit", 32'(seen), 32'd1);
    stall = 0;
    while (out_valid && !out_ready && stall < 20) begin
      chk("bp_no_fetch", 32'(in_ready), 32'd0);
      stall++;
      @(negedge clk);
    end
    chk("bp_stall_cycles", 32'(stall), 32'd5);
    chk("bp_handshake", 32'(out_valid && out_ready), 32'd1);
    @(negedge clk);
    chk("bp_fetch_resume", 32'(in_ready), 32'd1);
    chk("bp_tile_idx", 32'(tile_idx), 32'd1);
    wait_done("bp_done_timeout", 60);
    out_wait = 0;

    // Watchdog: small result never returns
    s_hold = 1'b1;
    pulse_start(1);
    @(negedge clk);
    chk("wd_fetch", 32'(in_ready && in_valid), 32'd1);
    @(negedge clk);
    chk("wd_run_entry", 32'(large_valid || small_valid), 32'd1);
    repeat (15) @(negedge clk);
    chk("wd_no_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("wd_done", 32'(done), 32'd1);
    chk("wd_err",  32'(err),  32'd1);
    chk("wd_idle", 32'(busy), 32'd0);
    s_hold = 1'b0;
    @(negedge clk);
    chk("wd_err_sticky", 32'(err), 32'd1);
    pulse_start(1);
    @(negedge clk);
    chk("wd_err_cleared", 32'(err), 32'd0);
    wait_done("wd_recover_timeout", 40);

    // Reset in RUN after only the large branch dispatched
    sr_wait = 50;
    pulse_start(1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (large_valid && large_ready) begin seen = 1; break; end
    end
    chk("rst_mid_dispatch", 32'(seen && small_valid && !small_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", 32'({in_ready, large_valid, small_valid, large_res_ready,
                             small_res_ready, out_valid, out_last, busy, done, err}), 32'd0);
    chk("rst_mid_idx", 32'(tile_idx), 32'd0);
    sr_wait = 0;
    base = outq.size();
    pulse_start(2);
    wait_done("rst_after_timeout", 60);
    chk("rst_after_count", 32'(outq.size() - base), 32'd2);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

module int_decomp_dummy_guard;
endmodule
